// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I-subset core.
// It steps the shared datapath through FETCH, DECODE, EXEC, MEM and WB.
// It drives the immediate-select, ALU and mux controls and every write strobe.
// It counts retired instructions and halts on an unsupported instruction.
// Control outputs are decoded from the state, the class captured in DECODE,
// instr, Zero and mem_ready, so strobes drop at once when rst_n falls.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCsrc,
  output logic [1:0]       ImmSrc,
  output logic             ALUsrc,
  output logic [2:0]       ALUctrl,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             ResultSrc,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_NONE  = 3'd0,
    C_ALUI  = 3'd1,
    C_ALUR  = 3'd2,
    C_LOAD  = 3'd3,
    C_STORE = 3'd4,
    C_BR    = 3'd5
  } iclass_t;

  state_t            state_r;
  iclass_t           class_r;
  iclass_t           decode_s;
  logic              illegal_r;
  logic [CNT_W-1:0]  retired_r;
  logic              unused_s;

  // The register-number fields are consumed by the datapath, not by this block.
  assign unused_s = ^{instr[24:15], instr[11:7]};

  // Map an instruction word onto one of the supported classes (C_NONE if unsupported).
  function automatic iclass_t classify(input logic [31:0] ins);
    iclass_t c;
    c = C_NONE;
    case (ins[6:0])
      7'b0010011: if (ins[14:12] == 3'b000) c = C_ALUI; else c = C_NONE;
      7'b0110011: begin
        if ((ins[14:12] == 3'b000) &&
            ((ins[31:25] == 7'b0000000) || (ins[31:25] == 7'b0100000))) c = C_ALUR;
        else c = C_NONE;
      end
      7'b0000011: if (ins[14:12] == 3'b010) c = C_LOAD; else c = C_NONE;
      7'b0100011: if (ins[14:12] == 3'b010) c = C_STORE; else c = C_NONE;
      7'b1100011: begin
        if ((ins[14:12] == 3'b000) || (ins[14:12] == 3'b001)) c = C_BR;
        else c = C_NONE;
      end
      default: c = C_NONE;
    endcase
    return c;
  endfunction

  assign decode_s = classify(instr);
  assign illegal  = illegal_r;
  assign retired  = retired_r;

  // Decode the per-cycle datapath controls from state, class, instr, Zero and mem_ready.
  always_comb begin
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCsrc     = 1'b0;
    ImmSrc    = 2'b00;
    ALUsrc    = 1'b0;
    ALUctrl   = 3'b000;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) IRWrite = 1'b1;
        else IRWrite = 1'b0;
      end
      S_EXEC: begin
        case (class_r)
          C_BR: begin
            ALUctrl = 3'b001;
            ImmSrc  = 2'b01;
            PCWrite = 1'b1;
            // funct3[0] distinguishes bne from beq
            if (instr[12]) PCsrc = ~Zero;
            else PCsrc = Zero;
          end
          C_ALUI: ALUsrc = 1'b1;
          C_ALUR: begin
            if (instr[30]) ALUctrl = 3'b001;
            else ALUctrl = 3'b000;
          end
          C_LOAD:  ALUsrc = 1'b1;
          C_STORE: begin
            ALUsrc = 1'b1;
            ImmSrc = 2'b10;
          end
          default: ALUsrc = 1'b0;
        endcase
      end
      S_MEM: begin
        // keep the address computation stable while memory is busy
        ALUsrc = 1'b1;
        if (class_r == C_STORE) ImmSrc = 2'b10;
        else ImmSrc = 2'b00;
        if (mem_ready && (class_r == C_STORE)) begin
          MemWrite = 1'b1;
          PCWrite  = 1'b1;
        end else begin
          MemWrite = 1'b0;
          PCWrite  = 1'b0;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        if (class_r == C_LOAD) ResultSrc = 1'b1;
        else ResultSrc = 1'b0;
      end
      default: IRWrite = 1'b0;
    endcase
  end

  // Advance the FSM, capture the decoded class, track illegal and count retirements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      class_r   <= C_NONE;
      illegal_r <= 1'b0;
      retired_r <= '0;
    end else begin
      if (PCWrite) retired_r <= retired_r + CNT_W'(1);
      else retired_r <= retired_r;
      case (state_r)
        S_IDLE:  state_r <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) state_r <= S_DECODE;
          else state_r <= S_FETCH;
        end
        S_DECODE: begin
          class_r <= decode_s;
          if (decode_s == C_NONE) begin
            state_r   <= S_HALT;
            illegal_r <= 1'b1;
          end else begin
            state_r <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (class_r)
            C_BR:            state_r <= S_FETCH;
            C_ALUI, C_ALUR:  state_r <= S_WB;
            C_LOAD, C_STORE: state_r <= S_MEM;
            default: begin
              state_r   <= S_HALT;
              illegal_r <= 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (!mem_ready) state_r <= S_MEM;
          else if (class_r == C_LOAD) state_r <= S_WB;
          else state_r <= S_FETCH;
        end
        S_WB:   state_r <= S_FETCH;
        S_HALT: state_r <= S_HALT;
        default: begin
          state_r   <= S_HALT;
          illegal_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios followed by
// random instruction streams with random memory wait states. Expected control
// patterns are built per instruction class from the published cycle recipes.
module tb_multicycle_ctrl;
  localparam int CNT_W = 4;

  // expected-control bit masks: {IRWrite,PCWrite,PCsrc,ImmSrc,ALUsrc,ALUctrl,MemWrite,RegWrite,ResultSrc,illegal}
  localparam logic [12:0] B_IRW  = 13'h1000;
  localparam logic [12:0] B_PCW  = 13'h0800;
  localparam logic [12:0] B_PCS  = 13'h0400;
  localparam logic [12:0] IMM_S  = 13'h0200;
  localparam logic [12:0] IMM_B  = 13'h0100;
  localparam logic [12:0] B_ASRC = 13'h0080;
  localparam logic [12:0] A_SUB  = 13'h0010;
  localparam logic [12:0] B_MW   = 13'h0008;
  localparam logic [12:0] B_RW   = 13'h0004;
  localparam logic [12:0] B_RS   = 13'h0002;
  localparam logic [12:0] B_ILL  = 13'h0001;
  localparam logic [12:0] NONE   = 13'h0000;

  logic clk, rst_n, Zero, mem_ready;
  logic [31:0] instr;
  logic IRWrite, PCWrite, PCsrc, ALUsrc, MemWrite, RegWrite, ResultSrc, illegal;
  logic [1:0] ImmSrc;
  logic [2:0] ALUctrl;
  logic [CNT_W-1:0] retired;
  logic [12:0] ctl_s;

  int n_vec = 0;
  int n_err = 0;
  int exp_ret = 0;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCsrc(PCsrc), .ImmSrc(ImmSrc),
    .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .illegal(illegal), .retired(retired)
  );

  assign ctl_s = {IRWrite, PCWrite, PCsrc, ImmSrc, ALUsrc, ALUctrl,
                  MemWrite, RegWrite, ResultSrc, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Class numbering: 0 unsupported, 1 addi, 2 add/sub, 3 lw, 4 sw, 5 beq/bne
  function automatic int spec_class(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    if (op == 7'b0010011 && f3 == 3'b000) return 1;
    if (op == 7'b0110011 && f3 == 3'b000 && (f7 == 7'h00 || f7 == 7'h20)) return 2;
    if (op == 7'b0000011 && f3 == 3'b010) return 3;
    if (op == 7'b0100011 && f3 == 3'b010) return 4;
    if (op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001)) return 5;
    return 0;
  endfunction

  // One clock cycle: drive inputs, check at negedge, advance, update retire model.
  task automatic do_cycle(input logic mr, input logic z, input logic [12:0] e, input string tag);
    mem_ready = mr;
    Zero = z;
    @(negedge clk);
    chk({tag, "/ctl"}, 32'(ctl_s), 32'(e));
    chk({tag, "/ret"}, 32'(retired), 32'(exp_ret));
    @(posedge clk);
    #1;
    if (e[11]) exp_ret = (exp_ret + 1) % (1 << CNT_W);
  endtask

  // Asynchronous reset mid-cycle with mem_ready high, then the IDLE cycle.
  task automatic reset_dut();
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst/ctl", 32'(ctl_s), 32'd0);
    chk("rst/ret", 32'(retired), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_ret = 0;
    do_cycle(rb(), rb(), NONE, "idle");
  endtask

  // Run one instruction from FETCH; abort_mem leaves it stuck in MEM for a reset.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input logic zx, input bit abort_mem);
    int c;
    logic [12:0] a;
    logic taken;
    instr = ins;
    for (int k = 0; k < fw; k++) do_cycle(1'b0, rb(), NONE, "fetch_wait");
    do_cycle(1'b1, rb(), B_IRW, "fetch");
    do_cycle(rb(), rb(), NONE, "decode");
    c = spec_class(ins);
    case (c)
      0: for (int k = 0; k < 20; k++) do_cycle(rb(), rb(), B_ILL, "halt");
      1: begin
        do_cycle(rb(), rb(), B_ASRC, "exec_alui");
        do_cycle(rb(), rb(), B_RW | B_PCW, "wb");
      end
      2: begin
        do_cycle(rb(), rb(), ins[30] ? A_SUB : NONE, "exec_alur");
        do_cycle(rb(), rb(), B_RW | B_PCW, "wb");
      end
      3, 4: begin
        a = B_ASRC | ((c == 4) ? IMM_S : NONE);
        do_cycle(rb(), rb(), a, "exec_mem");
        for (int k = 0; k < mw; k++) do_cycle(1'b0, rb(), a, "mem_wait");
        if (!abort_mem) begin
          if (c == 4) begin
            do_cycle(1'b1, rb(), a | B_MW | B_PCW, "mem_st");
          end else begin
            do_cycle(1'b1, rb(), a, "mem_ld");
            do_cycle(rb(), rb(), B_RW | B_PCW | B_RS, "wb_ld");
          end
        end
      end
      5: begin
        taken = ins[12] ? ~zx : zx;
        do_cycle(rb(), zx, A_SUB | IMM_B | B_PCW | (taken ? B_PCS : NONE), "exec_br");
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 5))
      0: w[6:0] = 7'b0010011;
      1: w[6:0] = 7'b0110011;
      2: w[6:0] = 7'b0000011;
      3: w[6:0] = 7'b0100011;
      4: w[6:0] = 7'b1100011;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[14:12] = 3'b000;
      1: w[14:12] = 3'b001;
      2: w[14:12] = 3'b010;
      default: ;
    endcase
    case ($urandom_range(0, 2))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    int c;
    bit ab;
    logic [31:0] ins;
    rst_n = 1'b1;
    instr = 32'h0;
    Zero = 1'b0;
    mem_ready = 1'b0;
    #3;
    reset_dut();

    // addi x1,x0,5 with no waits
    run_instr(32'h00500093, 0, 0, 1'b0, 1'b0);
    chk("addi_retired", 32'(retired), 32'd1);
    // beq taken, then bne not taken, both with Zero=1
    run_instr(32'h00000063, 0, 0, 1'b1, 1'b0);
    run_instr(32'h00001063, 0, 0, 1'b1, 1'b0);
    chk("br_retired", 32'(retired), 32'd3);
    // lw with three MEM wait cycles
    run_instr(32'h0000A103, 0, 3, 1'b0, 1'b0);
    // sw
    run_instr(32'h0020A223, 0, 0, 1'b0, 1'b0);
    // unsupported opcode: halt for 20 cycles, reset clears illegal
    run_instr(32'h0000007F, 0, 0, 1'b0, 1'b0);
    reset_dut();
    // 16 back-to-back addi wrap the 4-bit counter
    for (int k = 0; k < 16; k++) run_instr(32'h00500093, 0, 0, 1'b0, 1'b0);
    chk("wrap", 32'(retired), 32'd0);
    // reset during MEM of a store: the pending MemWrite must never appear
    run_instr(32'h0020A223, 0, 1, 1'b0, 1'b1);
    reset_dut();

    // random instruction streams
    for (int n = 0; n < 250; n++) begin
      ins = gen_instr();
      c = spec_class(ins);
      ab = ($urandom_range(0, 9) == 0);
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), rb(), ab);
      if (c == 0 || (ab && (c == 3 || c == 4))) reset_dut();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
